// File: rtl/ex_operand_stage_pkg.sv
// Shared constants for the decode-to-execute operand stage: width defaults,
// the hard-wired zero register index and the ALU funct codes.
package ex_operand_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int IMM_W_DEF  = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDU = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SUBU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd10;
    localparam logic [3:0] ALU_SRL  = 4'd11;
    localparam logic [3:0] ALU_SRA  = 4'd12;
    localparam logic [3:0] ALU_LUI  = 4'd13;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode-side, result-bus and ALU-side signals of the operand stage.
// The stage itself connects through the slave modport.
interface ex_operand_stage_if
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int IMM_W  = IMM_W_DEF
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs_idx;
    logic [REG_AW-1:0] in_rt_idx;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic [IMM_W-1:0]  in_imm;
    logic              in_imm_sext;
    logic              in_alu_src_imm;
    logic [4:0]        in_shamt;
    logic              in_shamt_reg;
    logic [3:0]        in_funct;
    logic              exm_wen;
    logic [REG_AW-1:0] exm_rd;
    logic [DATA_W-1:0] exm_data;
    logic              wb_wen;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
    logic [4:0]        shamt;
    logic [3:0]        funct;

    modport slave (
        input  flush, in_valid, in_rs_idx, in_rt_idx, in_rs_data, in_rt_data,
               in_imm, in_imm_sext, in_alu_src_imm, in_shamt, in_shamt_reg, in_funct,
               exm_wen, exm_rd, exm_data, wb_wen, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, operand1, operand2, shamt, funct
    );

    modport master (
        output flush, in_valid, in_rs_idx, in_rt_idx, in_rs_data, in_rt_data,
               in_imm, in_imm_sext, in_alu_src_imm, in_shamt, in_shamt_reg, in_funct,
               exm_wen, exm_rd, exm_data, wb_wen, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, operand1, operand2, shamt, funct
    );

endinterface

// File: rtl/ex_operand_stage_fwd_select.sv
// Forwarding mux for one source register: EX/MEM beats MEM/WB beats the
// supplied fallback data; the zero register is never forwarded.
module ex_operand_stage_fwd_select
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              exm_wen,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] sel_data
);

    always_comb begin
        sel_data = rf_data;
        if (idx != REG_AW'(REG_ZERO)) begin
            if (exm_wen && (exm_rd == idx)) begin
                sel_data = exm_data;
            end else if (wb_wen && (wb_rd == idx)) begin
                sel_data = wb_data;
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// Decode-to-execute operand register in front of the ALU. Forwarding and the
// stall-time snoop of held operands are enabled by EX_OPERAND_FORWARD_EN.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int IMM_W  = IMM_W_DEF
) (
    input logic                clk,
    input logic                rstn,
    ex_operand_stage_if.slave  bus
);

    logic              out_valid_reg;
    logic [DATA_W-1:0] operand1_reg;
    logic [DATA_W-1:0] operand2_reg;
    logic [4:0]        shamt_reg;
    logic [3:0]        funct_reg;
    logic [REG_AW-1:0] rs_idx_reg;
    logic [REG_AW-1:0] rt_idx_reg;
    logic              alu_src_imm_reg;
    logic              shamt_sel_reg;

    logic              accept;
    logic              hold;
    logic              exm_wen_eff;
    logic              wb_wen_eff;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] cap_op2;
    logic [4:0]        cap_shamt;

    logic [REG_AW-1:0] cap_idx [2];
    logic [DATA_W-1:0] cap_rf  [2];
    logic [DATA_W-1:0] cap_sel [2];

    assign bus.in_ready = ~out_valid_reg | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    assign hold         = out_valid_reg & ~bus.out_ready;

`ifdef EX_OPERAND_FORWARD_EN
    assign exm_wen_eff = bus.exm_wen;
    assign wb_wen_eff  = bus.wb_wen;
`else
    // Without forwarding the result buses are gated off so the selectors
    // always pass the register-file data through.
    assign exm_wen_eff = 1'b0;
    assign wb_wen_eff  = 1'b0;
    logic unused_fwd;
    assign unused_fwd = &{1'b0, bus.exm_wen, bus.wb_wen, rs_idx_reg, rt_idx_reg,
                          alu_src_imm_reg, shamt_sel_reg};
`endif

    assign cap_idx[0] = bus.in_rs_idx;
    assign cap_idx[1] = bus.in_rt_idx;
    assign cap_rf[0]  = bus.in_rs_data;
    assign cap_rf[1]  = bus.in_rt_data;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cap
        ex_operand_stage_fwd_select #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_fwd_select (
            .idx      (cap_idx[gi]),
            .rf_data  (cap_rf[gi]),
            .exm_wen  (exm_wen_eff),
            .exm_rd   (bus.exm_rd),
            .exm_data (bus.exm_data),
            .wb_wen   (wb_wen_eff),
            .wb_rd    (bus.wb_rd),
            .wb_data  (bus.wb_data),
            .sel_data (cap_sel[gi])
        );
    end

    assign imm_ext   = bus.in_imm_sext ? {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm}
                                       : {{(DATA_W-IMM_W){1'b0}}, bus.in_imm};
    assign cap_op2   = bus.in_alu_src_imm ? imm_ext : cap_sel[1];
    assign cap_shamt = bus.in_shamt_reg ? cap_sel[0][4:0] : bus.in_shamt;

`ifdef EX_OPERAND_FORWARD_EN
    // Snoop selectors fall back to the held operand, so no match means no change.
    logic [REG_AW-1:0] snp_idx [2];
    logic [DATA_W-1:0] snp_rf  [2];
    logic [DATA_W-1:0] snp_sel [2];

    assign snp_idx[0] = rs_idx_reg;
    assign snp_idx[1] = rt_idx_reg;
    assign snp_rf[0]  = operand1_reg;
    assign snp_rf[1]  = operand2_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_snp
        ex_operand_stage_fwd_select #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_fwd_select (
            .idx      (snp_idx[gi]),
            .rf_data  (snp_rf[gi]),
            .exm_wen  (bus.exm_wen),
            .exm_rd   (bus.exm_rd),
            .exm_data (bus.exm_data),
            .wb_wen   (bus.wb_wen),
            .wb_rd    (bus.wb_rd),
            .wb_data  (bus.wb_data),
            .sel_data (snp_sel[gi])
        );
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_reg   <= 1'b0;
            operand1_reg    <= '0;
            operand2_reg    <= '0;
            shamt_reg       <= '0;
            funct_reg       <= 4'd0;
            rs_idx_reg      <= '0;
            rt_idx_reg      <= '0;
            alu_src_imm_reg <= 1'b0;
            shamt_sel_reg   <= 1'b0;
        end else if (bus.flush) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg   <= 1'b1;
            operand1_reg    <= cap_sel[0];
            operand2_reg    <= cap_op2;
            shamt_reg       <= cap_shamt;
            funct_reg       <= bus.in_funct;
            rs_idx_reg      <= bus.in_rs_idx;
            rt_idx_reg      <= bus.in_rt_idx;
            alu_src_imm_reg <= bus.in_alu_src_imm;
            shamt_sel_reg   <= bus.in_shamt_reg;
        end else if (hold) begin
`ifdef EX_OPERAND_FORWARD_EN
            operand1_reg <= snp_sel[0];
            if (shamt_sel_reg) begin
                shamt_reg <= snp_sel[0][4:0];
            end
            if (!alu_src_imm_reg) begin
                operand2_reg <= snp_sel[1];
            end
`endif
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.operand1  = operand1_reg;
    assign bus.operand2  = operand2_reg;
    assign bus.shamt     = shamt_reg;
    assign bus.funct     = funct_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: a slot-level reference model is checked
// every cycle, and literal expectations pin each scenario.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    ex_operand_stage_if bus ();

    ex_operand_stage dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int beats    = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one slot describing what the ALU should currently see.
    typedef struct packed {
        logic        valid;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  shamt;
        logic [3:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        imm;
        logic        shreg;
    } slot_t;

    slot_t m;

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
`ifdef EX_OPERAND_FORWARD_EN
        if (idx == 5'd0) return rf;
        if (bus.exm_wen && bus.exm_rd == idx) return bus.exm_data;
        if (bus.wb_wen && bus.wb_rd == idx) return bus.wb_data;
`endif
        return rf;
    endfunction

    function automatic logic [31:0] ext(input logic [15:0] imm, input logic s);
        return s ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

    function automatic slot_t next_slot(input slot_t cur);
        slot_t n = cur;
        if (!rstn) return '0;
        if (bus.flush) begin
            n.valid = 1'b0;
            return n;
        end
        if (bus.in_valid && (!cur.valid || bus.out_ready)) begin
            n.valid = 1'b1;
            n.rs    = bus.in_rs_idx;
            n.rt    = bus.in_rt_idx;
            n.imm   = bus.in_alu_src_imm;
            n.shreg = bus.in_shamt_reg;
            n.funct = bus.in_funct;
            n.op1   = fwd(bus.in_rs_idx, bus.in_rs_data);
            n.op2   = bus.in_alu_src_imm ? ext(bus.in_imm, bus.in_imm_sext)
                                         : fwd(bus.in_rt_idx, bus.in_rt_data);
            n.shamt = bus.in_shamt_reg ? n.op1[4:0] : bus.in_shamt;
            return n;
        end
        if (cur.valid && !bus.out_ready) begin
            n.op1 = fwd(cur.rs, cur.op1);
            if (cur.shreg) n.shamt = n.op1[4:0];
            if (!cur.imm) n.op2 = fwd(cur.rt, cur.op2);
            return n;
        end
        n.valid = 1'b0;
        return n;
    endfunction

    always @(posedge clk) m <= next_slot(m);

    always @(negedge clk) begin
        if (check_en) begin
            chk("model out_valid", 32'(bus.out_valid), 32'(m.valid));
            chk("model in_ready", 32'(bus.in_ready), 32'(!m.valid || bus.out_ready));
            if (m.valid) begin
                chk("model operand1", bus.operand1, m.op1);
                chk("model operand2", bus.operand2, m.op2);
                chk("model shamt", 32'(bus.shamt), 32'(m.shamt));
                chk("model funct", 32'(bus.funct), 32'(m.funct));
            end
            if (bus.out_valid && bus.out_ready) begin
                beats++;
                $display("beat %0d: op1=0x%08h op2=0x%08h shamt=%0d funct=%0d",
                         beats, bus.operand1, bus.operand2, bus.shamt, bus.funct);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [31:0] rsd,
                             input logic [4:0] rt, input logic [31:0] rtd,
                             input logic [3:0] fn);
        bus.in_rs_idx  = rs;
        bus.in_rs_data = rsd;
        bus.in_rt_idx  = rt;
        bus.in_rt_data = rtd;
        bus.in_funct   = fn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int beats_start;
        logic [31:0] exp_op1;
        logic [31:0] exp_op2;
        logic [4:0]  exp_sh;

        rstn               = 1'b0;
        bus.flush          = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_imm         = '0;
        bus.in_imm_sext    = 1'b0;
        bus.in_alu_src_imm = 1'b0;
        bus.in_shamt       = '0;
        bus.in_shamt_reg   = 1'b0;
        bus.exm_wen        = 1'b0;
        bus.exm_rd         = '0;
        bus.exm_data       = '0;
        bus.wb_wen         = 1'b0;
        bus.wb_rd          = '0;
        bus.wb_data        = '0;
        bus.out_ready      = 1'b0;
        set_instr(5'd0, 32'h0, 5'd0, 32'h0, ALU_ADD);
        tick();
        tick();
        $display("txn reset");
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset operand1", bus.operand1, 32'h0);
        chk("reset operand2", bus.operand2, 32'h0);
        chk("reset shamt", 32'(bus.shamt), 32'd0);
        chk("reset funct", 32'(bus.funct), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        check_en = 1'b1;
        rstn     = 1'b1;

        // Plain capture, then 8 back-to-back instructions.
        set_instr(5'd3, 32'h10, 5'd4, 32'h20, ALU_ADDU);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        $display("txn plain capture");
        chk("plain out_valid", 32'(bus.out_valid), 32'd1);
        chk("plain operand1", bus.operand1, 32'h10);
        chk("plain operand2", bus.operand2, 32'h20);
        chk("plain funct", 32'(bus.funct), 32'(ALU_ADDU));
        for (int i = 0; i < 8; i++) begin
            set_instr(5'd3, 32'h100 + 32'(i), 5'd4, 32'h200 + 32'(i), ALU_SUBU);
            tick();
            $display("txn back-to-back %0d", i);
            chk("b2b out_valid", 32'(bus.out_valid), 32'd1);
            chk("b2b operand1", bus.operand1, 32'h100 + 32'(i));
            chk("b2b operand2", bus.operand2, 32'h200 + 32'(i));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("drain out_valid", 32'(bus.out_valid), 32'd0);

        // Immediate source with sign and zero extension.
        bus.in_valid       = 1'b1;
        bus.in_alu_src_imm = 1'b1;
        bus.in_imm         = 16'hFFF0;
        bus.in_imm_sext    = 1'b1;
        tick();
        $display("txn imm sext");
        chk("imm sext operand2", bus.operand2, 32'hFFFF_FFF0);
        bus.in_imm_sext = 1'b0;
        tick();
        $display("txn imm zext");
        chk("imm zext operand2", bus.operand2, 32'h0000_FFF0);
        bus.in_alu_src_imm = 1'b0;

        // Forward priority.
        set_instr(5'd5, 32'h55, 5'd6, 32'h66, ALU_OR);
        bus.exm_wen = 1'b1; bus.exm_rd = 5'd5; bus.exm_data = 32'hAAAA;
        bus.wb_wen  = 1'b1; bus.wb_rd  = 5'd5; bus.wb_data  = 32'hBBBB;
        tick();
        $display("txn forward exm");
`ifdef EX_OPERAND_FORWARD_EN
        exp_op1 = 32'hAAAA;
`else
        exp_op1 = 32'h55;
`endif
        chk("fwd exm operand1", bus.operand1, exp_op1);
        bus.exm_wen = 1'b0;
        tick();
        $display("txn forward wb");
`ifdef EX_OPERAND_FORWARD_EN
        exp_op1 = 32'hBBBB;
`else
        exp_op1 = 32'h55;
`endif
        chk("fwd wb operand1", bus.operand1, exp_op1);
        set_instr(5'd0, 32'h77, 5'd6, 32'h66, ALU_OR);
        bus.exm_wen = 1'b1; bus.exm_rd = 5'd0;
        bus.wb_rd   = 5'd0;
        tick();
        $display("txn forward r0");
        chk("fwd r0 operand1", bus.operand1, 32'h77);
        bus.exm_wen  = 1'b0;
        bus.wb_wen   = 1'b0;
        bus.in_valid = 1'b0;
        tick();

        // Stall snoop on held rt.
        set_instr(5'd1, 32'h11, 5'd7, 32'h700, ALU_XOR);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        $display("txn snoop capture");
        chk("snoop capture operand2", bus.operand2, 32'h700);
        tick();
        chk("snoop hold out_valid", 32'(bus.out_valid), 32'd1);
        chk("snoop hold in_ready", 32'(bus.in_ready), 32'd0);
        bus.wb_wen = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h1234;
        tick();
        bus.wb_wen = 1'b0;
        $display("txn snoop wb");
`ifdef EX_OPERAND_FORWARD_EN
        exp_op2 = 32'h1234;
`else
        exp_op2 = 32'h700;
`endif
        chk("snoop operand2", bus.operand2, exp_op2);
        chk("snoop out_valid", 32'(bus.out_valid), 32'd1);
        chk("snoop funct", 32'(bus.funct), 32'(ALU_XOR));
        beats_start   = beats;
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("snoop release beats", 32'(beats - beats_start), 32'd1);
        chk("snoop release out_valid", 32'(bus.out_valid), 32'd0);

        // Flush with simultaneous accept.
        set_instr(5'd2, 32'h222, 5'd3, 32'h333, ALU_AND);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        $display("txn flush");
        chk("flush out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush operand1 held", bus.operand1, 32'h11);

        // Reset during a hold.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("prehold out_valid", 32'(bus.out_valid), 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        $display("txn reset in hold");
        chk("hold reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("hold reset operand1", bus.operand1, 32'h0);
        chk("hold reset operand2", bus.operand2, 32'h0);
        chk("hold reset funct", 32'(bus.funct), 32'd0);
        chk("hold reset in_ready", 32'(bus.in_ready), 32'd1);

        // Variable shift amount from a forwarded rs.
        set_instr(5'd9, 32'h0000_00FE, 5'd4, 32'h4, ALU_SLL);
        bus.in_shamt     = 5'd17;
        bus.in_shamt_reg = 1'b1;
        bus.exm_wen = 1'b1; bus.exm_rd = 5'd9; bus.exm_data = 32'h0000_0023;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        $display("txn variable shift");
`ifdef EX_OPERAND_FORWARD_EN
        exp_sh = 5'd3;
`else
        exp_sh = 5'd30;
`endif
        chk("varshift shamt", 32'(bus.shamt), 32'(exp_sh));
        bus.in_shamt_reg = 1'b0;
        bus.exm_wen      = 1'b0;
        tick();
        $display("txn fixed shift");
        chk("fixshift shamt", 32'(bus.shamt), 32'd17);
        bus.in_valid = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Decode-to-execute pipeline register that sits directly upstream of the ALU.
- Latches one decoded instruction per handshake and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB result buses.
- Selects the immediate or register source and presents registered operand1/operand2/shamt/funct straight to ALU inputs.
- Provides valid/ready back-pressure and a synchronous flush for branch squash.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register index width
- IMM_W, 16, raw immediate width

Ports:
- clk  in  1  sole clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- flush  in  1  squash held/incoming instruction
- in_valid  in  1  decode has instruction
- in_ready  out  1  stage can accept
- in_rs_idx, in_rt_idx  in  REG_AW  source indices
- in_rs_data, in_rt_data  in  DATA_W  regfile read data
- in_imm  in  IMM_W  raw immediate
- in_imm_sext  in  1  1=sign-extend, 0=zero-extend
- in_alu_src_imm  in  1  operand2 = extended immediate
- in_shamt  in  5  instruction shamt field
- in_shamt_reg  in  1  shamt = rs[4:0] (variable shifts)
- in_funct  in  4  ALU opcode (GLOBAL.v ALU_* codes)
- exm_wen  in  1; exm_rd  in  REG_AW; exm_data  in  DATA_W  EX/MEM result
- wb_wen  in  1; wb_rd  in  REG_AW; wb_data  in  DATA_W  MEM/WB result
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  execute consumes
- operand1, operand2  out  DATA_W
- shamt  out  5
- funct  out  4

Behaviour:
- Reset: at posedge clk with rstn=0, out_valid=0, operand1=operand2=0, shamt=0, funct=4'd0, held indices and control bits cleared. Overrides flush and capture.
- in_ready = ~out_valid | out_ready (combinational). A slot that is freed this cycle may be refilled this cycle.
- Accept = in_valid & in_ready. Outputs update at the next posedge (1-cycle latency). Zero-bubble throughput when out_ready=1.
- Flush (rstn=1) has priority at the same posedge: out_valid<=0 and any simultaneously accepted instruction is discarded. Data outputs hold their old values.
- out_valid=1 & out_ready=0 & no flush: instruction held; out_valid and funct stable.
- Forward select per source s in {rs, rt}:
  - if exm_wen & exm_rd==s & s!=0, use exm_data
  - else if wb_wen & wb_rd==s & s!=0, use wb_data
  - else use the regfile data
  - Index 0 is never forwarded.
- operand1 = fwd(rs).
- operand2 = in_alu_src_imm ? ext(in_imm) : fwd(rt). ext is sign or zero extension to DATA_W per in_imm_sext.
- shamt = in_shamt_reg ? fwd(rs)[4:0] : in_shamt.
- Stall snoop: while held, each posedge re-applies the forwarding rules, with the same priority, to the stored rs/rt indices.
  - rs match updates operand1; it also updates shamt if held shamt_reg=1.
  - rt match updates operand2 only if held alu_src_imm=0.
  - Snoop never alters out_valid.
- Outputs are registered only; there is no combinational in→out path except in_ready←out_ready/out_valid.

Optional Feature:
- Macro: EX_OPERAND_FORWARD_EN.
- Defined: forwarding and stall snoop as above.
- Undefined: exm_*/wb_* ports remain but are ignored; operands come directly from in_rs_data/in_rt_data; no snoop. The hazard unit must stall instead.

Decomposition:
- GLOBAL.v holds the ALU_* funct codes, a REG_ZERO index constant and the width defaults. No new typedefs.
- One sub-module, fwd_select: combinational, with index, regfile data and both result buses in, and selected data out.
  - Instantiated twice for capture (rs, rt).
  - Instantiated twice for snoop on the held indices.

Test Plan:
- Plain capture: rs=3 data 0x10, rt=4 data 0x20, funct=ALU_ADDU, in_valid=1, out_ready=1, no forwards → next cycle out_valid=1, operand1=0x10, operand2=0x20. Throughput 1/cycle over 8 back-to-back instructions.
- Immediate: in_alu_src_imm=1, in_imm=0xFFF0, sext=1 → operand2=0xFFFFFFF0. Same with sext=0 → operand2=0x0000FFF0.
- Forward priority: rs=5, exm_rd=5 data 0xAAAA, wb_rd=5 data 0xBBBB → operand1=0xAAAA. With rs=0 and exm_rd=0 → regfile data is used.
- Stall snoop: held rt=7 with out_ready=0 for 2 cycles; wb_wen rd=7 data 0x1234 in cycle 2 → operand2=0x1234 and out_valid stays 1. Setting out_ready=1 then gives exactly one consumed beat.
- Flush/reset: flush=1 together with an accept → out_valid=0 next cycle. rstn=0 during a hold → all outputs 0 and in_ready=1.
- Variable shift: in_shamt_reg=1, rs forwarded 0x00000023 → shamt=3. Without EX_OPERAND_FORWARD_EN, the same stimulus yields the regfile value.
